// File: rtl/pt_update_scheduler.sv
// pt_update_scheduler
// Arbitrates the pattern table's single write port between the ID rollback
// restore, EX rollback correction and corrected-result training update
// sources. Updates that cannot be written in the current cycle go into a small
// coalescing FIFO. A read bypass lets predictions see pending values, and the
// whole table is swept to INIT_VALUE after every reset.
module pt_update_scheduler #(
    parameter int unsigned              INDEX_WIDTH   = 12,
    parameter int unsigned              COUNTER_WIDTH = 2,
    parameter logic [COUNTER_WIDTH-1:0] INIT_VALUE    = '0,
    parameter int unsigned              QUEUE_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_upd_valid,
    input  logic [INDEX_WIDTH-1:0]   id_upd_index,
    input  logic [COUNTER_WIDTH-1:0] id_upd_count,
    input  logic                     ex_upd_valid,
    input  logic [INDEX_WIDTH-1:0]   ex_upd_index,
    input  logic [COUNTER_WIDTH-1:0] ex_upd_count,
    input  logic                     cr_upd_valid,
    input  logic [INDEX_WIDTH-1:0]   cr_upd_index,
    input  logic [COUNTER_WIDTH-1:0] cr_upd_count,
    input  logic [INDEX_WIDTH-1:0]   rd_index,
    input  logic [COUNTER_WIDTH-1:0] rd_count_raw,
    output logic [COUNTER_WIDTH-1:0] rd_count,
    output logic                     tbl_wr_en,
    output logic [INDEX_WIDTH-1:0]   tbl_wr_index,
    output logic [COUNTER_WIDTH-1:0] tbl_wr_count,
    output logic                     init_busy,
    output logic                     upd_ready,
    output logic                     overflow,
    output logic                     protocol_err
);

    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned OW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                   state, state_nxt;
    logic [INDEX_WIDTH-1:0]   sweep, sweep_nxt;

    logic [INDEX_WIDTH-1:0]   q_idx   [QUEUE_DEPTH];
    logic [COUNTER_WIDTH-1:0] q_cnt   [QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0]   nxt_idx [QUEUE_DEPTH];
    logic [COUNTER_WIDTH-1:0] nxt_cnt [QUEUE_DEPTH];
    logic [PW-1:0]            head, tail, nxt_head, nxt_tail;
    logic [OW-1:0]            occ, nxt_occ;
    logic                     overflow_r, protocol_err_r;

    // New requests after preprocessing, in global order: 0=EX, 1=ID, 2=CR
    logic [2:0]               n_vld;
    logic [INDEX_WIDTH-1:0]   n_idx [3];
    logic [COUNTER_WIDTH-1:0] n_cnt [3];

    logic [QUEUE_DEPTH-1:0]   live;
    logic [PW-1:0]            p, bp;
    logic                     taken, hit, drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(QUEUE_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Resolve EX/CR exclusivity and the ID-vs-EX same-index collision
    always_comb begin
        n_vld[0] = ex_upd_valid;
        n_vld[1] = id_upd_valid && !(ex_upd_valid && (id_upd_index == ex_upd_index));
        n_vld[2] = cr_upd_valid && !ex_upd_valid;
        n_idx[0] = ex_upd_index;
        n_idx[1] = id_upd_index;
        n_idx[2] = cr_upd_index;
        n_cnt[0] = ex_upd_count;
        n_cnt[1] = id_upd_count;
        n_cnt[2] = cr_upd_count;
    end

    // Init sweep sequencing and INIT -> RUN transition
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        if (state == ST_INIT) begin
            sweep_nxt = sweep + 1'b1;
            if (sweep == '1) begin
                state_nxt = ST_RUN;
            end
        end
    end

    // Write-port selection, coalescing and enqueue of this cycle's requests
    always_comb begin
        nxt_idx      = q_idx;
        nxt_cnt      = q_cnt;
        nxt_head     = head;
        nxt_tail     = tail;
        nxt_occ      = occ;
        live         = '0;
        tbl_wr_en    = 1'b0;
        tbl_wr_index = '0;
        tbl_wr_count = '0;
        taken        = 1'b0;
        hit          = 1'b0;
        drop         = 1'b0;
        p            = head;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            if (OW'(i) < occ) begin
                live[p] = 1'b1;
            end
            p = ptr_inc(p);
        end
        if (state == ST_INIT) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = sweep;
            tbl_wr_count = INIT_VALUE;
        end else begin
            if (occ != '0) begin
                tbl_wr_en    = 1'b1;
                tbl_wr_index = q_idx[head];
                tbl_wr_count = q_cnt[head];
                live[head]   = 1'b0;
                nxt_head     = ptr_inc(head);
                nxt_occ      = occ - 1'b1;
                taken        = 1'b1;
            end
            // Slots filled earlier in this loop are marked live so later
            // requests in the same cycle coalesce into them too.
            for (int unsigned n = 0; n < 3; n++) begin
                if (n_vld[2'(n)]) begin
                    if (!taken) begin
                        tbl_wr_en    = 1'b1;
                        tbl_wr_index = n_idx[2'(n)];
                        tbl_wr_count = n_cnt[2'(n)];
                        taken        = 1'b1;
                    end else begin
                        hit = 1'b0;
                        for (int unsigned s = 0; s < QUEUE_DEPTH; s++) begin
                            if (live[PW'(s)] && (nxt_idx[PW'(s)] == n_idx[2'(n)])) begin
                                nxt_cnt[PW'(s)] = n_cnt[2'(n)];
                                hit             = 1'b1;
                            end
                        end
                        if (!hit) begin
                            if (nxt_occ < OW'(QUEUE_DEPTH)) begin
                                nxt_idx[nxt_tail] = n_idx[2'(n)];
                                nxt_cnt[nxt_tail] = n_cnt[2'(n)];
                                live[nxt_tail]    = 1'b1;
                                nxt_tail          = ptr_inc(nxt_tail);
                                nxt_occ           = nxt_occ + 1'b1;
                            end else begin
                                drop = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Read bypass: last pending writer to rd_index wins, else table data
    always_comb begin
        rd_count = rd_count_raw;
        bp       = head;
        if (state == ST_INIT) begin
            rd_count = INIT_VALUE;
        end else begin
            // Offset 0 is the head, which is being written this cycle.
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                if ((i != 0) && (OW'(i) < occ) && (q_idx[bp] == rd_index)) begin
                    rd_count = q_cnt[bp];
                end
                bp = ptr_inc(bp);
            end
            for (int unsigned n = 0; n < 3; n++) begin
                if (n_vld[2'(n)] && (n_idx[2'(n)] == rd_index)) begin
                    rd_count = n_cnt[2'(n)];
                end
            end
        end
    end

    // Status outputs
    always_comb begin
        init_busy    = (state == ST_INIT);
        upd_ready    = (state == ST_RUN) && (occ <= OW'(QUEUE_DEPTH - 2));
        overflow     = overflow_r;
        protocol_err = protocol_err_r;
    end

    // FSM, sweep counter, queue pointers and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_INIT;
            sweep          <= '0;
            head           <= '0;
            tail           <= '0;
            occ            <= '0;
            overflow_r     <= 1'b0;
            protocol_err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
            head  <= nxt_head;
            tail  <= nxt_tail;
            occ   <= nxt_occ;
            if (drop) begin
                overflow_r <= 1'b1;
            end
            if ((state == ST_RUN) && ex_upd_valid && cr_upd_valid) begin
                protocol_err_r <= 1'b1;
            end
        end
    end

    // Queue payload storage; validity is tracked by head/occupancy only
    always_ff @(posedge clk) begin
        q_idx <= nxt_idx;
        q_cnt <= nxt_cnt;
    end

endmodule

// File: tb/tb_pt_update_scheduler.sv
// Testbench for pt_update_scheduler: expected table writes go into a
// scoreboard queue as stimulus is driven and are checked as they appear.
module tb_pt_update_scheduler;

    localparam int unsigned IW    = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned QD    = 4;
    localparam logic [CW-1:0] INITV = 2'd1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_upd_valid, ex_upd_valid, cr_upd_valid;
    logic [IW-1:0] id_upd_index, ex_upd_index, cr_upd_index;
    logic [CW-1:0] id_upd_count, ex_upd_count, cr_upd_count;
    logic [IW-1:0] rd_index;
    logic [CW-1:0] rd_count_raw, rd_count;
    logic          tbl_wr_en;
    logic [IW-1:0] tbl_wr_index;
    logic [CW-1:0] tbl_wr_count;
    logic          init_busy, upd_ready, overflow, protocol_err;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
    } wr_t;

    wr_t exp_q[$];
    wr_t sb_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  sb_on    = 1'b0;

    always #5 clk = ~clk;

    pt_update_scheduler #(
        .INDEX_WIDTH  (IW),
        .COUNTER_WIDTH(CW),
        .INIT_VALUE   (INITV),
        .QUEUE_DEPTH  (QD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_upd_valid(id_upd_valid),
        .id_upd_index(id_upd_index),
        .id_upd_count(id_upd_count),
        .ex_upd_valid(ex_upd_valid),
        .ex_upd_index(ex_upd_index),
        .ex_upd_count(ex_upd_count),
        .cr_upd_valid(cr_upd_valid),
        .cr_upd_index(cr_upd_index),
        .cr_upd_count(cr_upd_count),
        .rd_index    (rd_index),
        .rd_count_raw(rd_count_raw),
        .rd_count    (rd_count),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_index(tbl_wr_index),
        .tbl_wr_count(tbl_wr_count),
        .init_busy   (init_busy),
        .upd_ready   (upd_ready),
        .overflow    (overflow),
        .protocol_err(protocol_err)
    );

    // Scoreboard: every observed table write must match the next expected one
    always @(negedge clk) begin
        if (sb_on && tbl_wr_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got idx %0d cnt %0d, required no write",
                         tbl_wr_index, tbl_wr_count);
            end else begin
                sb_e = exp_q.pop_front();
                if ({tbl_wr_index, tbl_wr_count} !== sb_e) begin
                    n_fail++;
                    $display("FAIL sb_write: got idx %0d cnt %0d, required idx %0d cnt %0d",
                             tbl_wr_index, tbl_wr_count, sb_e.idx, sb_e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] idx, input logic [CW-1:0] cnt);
        exp_q.push_back({idx, cnt});
    endtask

    task automatic drive(input logic ev, input logic [IW-1:0] ei, input logic [CW-1:0] ec,
                         input logic iv, input logic [IW-1:0] ii, input logic [CW-1:0] ic,
                         input logic cv, input logic [IW-1:0] ci, input logic [CW-1:0] cc);
        ex_upd_valid = ev; ex_upd_index = ei; ex_upd_count = ec;
        id_upd_valid = iv; id_upd_index = ii; id_upd_count = ic;
        cr_upd_valid = cv; cr_upd_index = ci; cr_upd_count = cc;
    endtask

    task automatic idle();
        drive(0, '0, '0, 0, '0, '0, 0, '0, '0);
        rd_index     = '0;
        rd_count_raw = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        for (int k = 0; k < 16; k++) push(IW'(k), INITV);
        sb_on = 1'b1;
        rst_n = 1'b1;
        // A request during init must be ignored
        drive(0, '0, '0, 0, '0, '0, 1, 4'd3, 2'd2);
        rd_index     = 4'd3;
        rd_count_raw = 2'd2;
        for (int k = 0; k < 16; k++) begin
            sample_point();
            n_checks++;
            if (init_busy !== 1'b1 || upd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL init_flags[%0d]: got busy %b ready %b, required busy 1 ready 0",
                         k, init_busy, upd_ready);
            end
            n_checks++;
            if (rd_count !== INITV) begin
                n_fail++;
                $display("FAIL init_rd_count[%0d]: got %0d, required %0d", k, rd_count, INITV);
            end
            if (k == 0) begin
                n_checks++;
                if (overflow !== 1'b0 || protocol_err !== 1'b0 || tbl_wr_index !== '0) begin
                    n_fail++;
                    $display("FAIL reset_state: got ovf %b perr %b idx %0d, required 0 0 0",
                             overflow, protocol_err, tbl_wr_index);
                end
            end
            next_cycle();
        end
        idle();
        sample_point();
        n_checks++;
        if (init_busy !== 1'b0 || upd_ready !== 1'b1 || tbl_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL init_done: got busy %b ready %b wr_en %b, required 0 1 0",
                     init_busy, upd_ready, tbl_wr_en);
        end
        n_checks++;
        if (exp_q.size() != 0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL init_writes: got %0d missing writes ovf %b, required 0 and 0",
                     exp_q.size(), overflow);
        end
        next_cycle();
    endtask

    task automatic test_single_cr();
        drive(0, '0, '0, 0, '0, '0, 1, 4'd5, 2'd3);
        rd_index = 4'd5;
        push(4'd5, 2'd3);
        sample_point();
        n_checks++;
        if (rd_count !== 2'd3) begin
            n_fail++;
            $display("FAIL single_cr_bypass: got %0d, required 3", rd_count);
        end
        next_cycle();
        idle();
        sample_point();
        n_checks++;
        if (exp_q.size() != 0 || tbl_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cr_latency: got %0d pending wr_en %b, required 0 and 0",
                     exp_q.size(), tbl_wr_en);
        end
        next_cycle();
    endtask

    task automatic test_ex_id_pair();
        drive(1, 4'd2, 2'd1, 1, 4'd7, 2'd2, 0, '0, '0);
        rd_index = 4'd7;
        push(4'd2, 2'd1);
        push(4'd7, 2'd2);
        sample_point();
        n_checks++;
        if (rd_count !== 2'd2) begin
            n_fail++;
            $display("FAIL pair_bypass_new: got %0d, required 2", rd_count);
        end
        next_cycle();
        idle();
        rd_index     = 4'd7;
        rd_count_raw = 2'd3;
        sample_point();
        n_checks++;
        if (rd_count !== 2'd3) begin
            n_fail++;
            $display("FAIL pair_bypass_head_excluded: got %0d, required 3", rd_count);
        end
        next_cycle();
        sample_point();
        n_checks++;
        if (exp_q.size() != 0 || tbl_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_drain: got %0d pending wr_en %b, required 0 and 0",
                     exp_q.size(), tbl_wr_en);
        end
        next_cycle();
    endtask

    task automatic test_same_index();
        drive(1, 4'd9, 2'd0, 1, 4'd9, 2'd3, 0, '0, '0);
        rd_index     = 4'd9;
        rd_count_raw = 2'd2;
        push(4'd9, 2'd0);
        sample_point();
        n_checks++;
        if (rd_count !== 2'd0) begin
            n_fail++;
            $display("FAIL same_idx_bypass: got %0d, required 0", rd_count);
        end
        next_cycle();
        idle();
        sample_point();
        n_checks++;
        if (exp_q.size() != 0 || tbl_wr_en !== 1'b0 || protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL same_idx_result: got %0d pending wr_en %b perr %b, required 0 0 0",
                     exp_q.size(), tbl_wr_en, protocol_err);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ready_exp;
        ready_exp = 4'b0111;   // ready seen in cycles a..d: a=1 b=1 c=1 d=0
        drive(1, 4'd10, 2'd1, 1, 4'd11, 2'd1, 0, '0, '0);
        push(4'd10, 2'd1); push(4'd11, 2'd1);
        sample_point();
        n_checks++;
        if (upd_ready !== ready_exp[0]) begin
            n_fail++; $display("FAIL b2b_ready_a: got %b, required 1", upd_ready);
        end
        next_cycle();
        drive(1, 4'd12, 2'd1, 1, 4'd13, 2'd1, 0, '0, '0);
        push(4'd12, 2'd1); push(4'd13, 2'd1);
        sample_point();
        n_checks++;
        if (upd_ready !== ready_exp[1]) begin
            n_fail++; $display("FAIL b2b_ready_b: got %b, required 1", upd_ready);
        end
        next_cycle();
        drive(1, 4'd14, 2'd1, 1, 4'd15, 2'd1, 0, '0, '0);
        push(4'd14, 2'd1); push(4'd15, 2'd1);
        sample_point();
        n_checks++;
        if (upd_ready !== ready_exp[2]) begin
            n_fail++; $display("FAIL b2b_ready_c: got %b, required 1", upd_ready);
        end
        next_cycle();
        drive(1, 4'd1, 2'd1, 1, 4'd4, 2'd1, 0, '0, '0);
        push(4'd1, 2'd1);
        sample_point();
        n_checks++;
        if (upd_ready !== ready_exp[3] || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_d: got ready %b ovf %b, required 0 0", upd_ready, overflow);
        end
        next_cycle();
        // Queue is full at the start of this cycle: the ID request is dropped
        drive(1, 4'd2, 2'd1, 1, 4'd3, 2'd1, 0, '0, '0);
        sample_point();
        n_checks++;
        if (upd_ready !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got ready %b ovf %b, required 0 0", upd_ready, overflow);
        end
        next_cycle();
        // Coalesce a CR update into the queued idx 4 entry
        drive(0, '0, '0, 0, '0, '0, 1, 4'd4, 2'd3);
        rd_index = 4'd4;
        push(4'd4, 2'd3); push(4'd2, 2'd1);
        sample_point();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL b2b_overflow: got %b, required 1", overflow);
        end
        n_checks++;
        if (rd_count !== 2'd3) begin
            n_fail++; $display("FAIL b2b_bypass_new: got %0d, required 3", rd_count);
        end
        next_cycle();
        idle();
        rd_index = 4'd4;
        sample_point();
        n_checks++;
        if (rd_count !== 2'd3 || upd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_coalesced: got rd %0d ready %b, required 3 0", rd_count, upd_ready);
        end
        next_cycle();
        sample_point();
        n_checks++;
        if (upd_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_occupancy: got ready %b, required 1", upd_ready);
        end
        next_cycle();
        next_cycle();
        sample_point();
        n_checks++;
        if (exp_q.size() != 0 || tbl_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending wr_en %b, required 0 and 0",
                     exp_q.size(), tbl_wr_en);
        end
        next_cycle();
    endtask

    task automatic test_protocol_err();
        drive(1, 4'd6, 2'd2, 0, '0, '0, 1, 4'd8, 2'd1);
        rd_index     = 4'd8;
        rd_count_raw = 2'd1;
        push(4'd6, 2'd2);
        sample_point();
        n_checks++;
        if (rd_count !== 2'd1 || protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_cycle: got rd %0d perr %b, required 1 0", rd_count, protocol_err);
        end
        next_cycle();
        idle();
        sample_point();
        n_checks++;
        if (protocol_err !== 1'b1 || tbl_wr_en !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL perr_after: got perr %b wr_en %b pending %0d, required 1 0 0",
                     protocol_err, tbl_wr_en, exp_q.size());
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_drain();
        drive(1, 4'd1, 2'd1, 1, 4'd2, 2'd1, 0, '0, '0);
        push(4'd1, 2'd1); push(4'd2, 2'd1);
        next_cycle();
        drive(1, 4'd3, 2'd1, 1, 4'd5, 2'd1, 0, '0, '0);
        next_cycle();
        idle();
        sb_on = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        next_cycle();
        for (int k = 0; k < 16; k++) push(IW'(k), INITV);
        sb_on = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sample_point();
            n_checks++;
            if (init_busy !== 1'b1 || tbl_wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_reset_sweep[%0d]: got busy %b wr_en %b, required 1 1",
                         k, init_busy, tbl_wr_en);
            end
            if (k == 0) begin
                n_checks++;
                if (tbl_wr_index !== '0 || overflow !== 1'b0 || protocol_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_reset_state: got idx %0d ovf %b perr %b, required 0 0 0",
                             tbl_wr_index, overflow, protocol_err);
                end
            end
            next_cycle();
        end
        sample_point();
        n_checks++;
        if (init_busy !== 1'b0 || tbl_wr_en !== 1'b0 || upd_ready !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_flushed: got busy %b wr_en %b ready %b pending %0d, required 0 0 1 0",
                     init_busy, tbl_wr_en, upd_ready, exp_q.size());
        end
        next_cycle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_cr();
        test_ex_id_pair();
        test_same_index();
        test_back_to_back();
        test_protocol_err();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pt_update_scheduler.md
# pt_update_scheduler

Write-port scheduler for the history predictor's pattern table. It arbitrates the three counter-update sources (ID-stage rollback restore, EX-stage rollback correction, corrected-result training) onto the table's single write port. Updates that cannot be written in the current cycle are held in a small coalescing queue. It provides a read bypass so predictions see pending values, and after every reset it sweeps the whole table to the counter init value before normal operation.

## Interface
- INDEX_WIDTH, 12, table index width; table holds 2^INDEX_WIDTH counters
- COUNTER_WIDTH, 2, saturating jump-status counter width
- INIT_VALUE, 0, counter value written during init sweep (COUNTER_WIDTH bits)
- QUEUE_DEPTH, 4, pending-update queue entries (>= 2)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- id_upd_valid / id_upd_index / id_upd_count  in  1 / INDEX_WIDTH / COUNTER_WIDTH  ID rollback restore request
- ex_upd_valid / ex_upd_index / ex_upd_count  in  1 / INDEX_WIDTH / COUNTER_WIDTH  EX rollback correction request
- cr_upd_valid / cr_upd_index / cr_upd_count  in  1 / INDEX_WIDTH / COUNTER_WIDTH  corrected-result training request
- rd_index  in  INDEX_WIDTH  prediction lookup index (same as table read index)
- rd_count_raw  in  COUNTER_WIDTH  table read data
- rd_count  out  COUNTER_WIDTH  bypassed prediction counter
- tbl_wr_en / tbl_wr_index / tbl_wr_count  out  1 / INDEX_WIDTH / COUNTER_WIDTH  table write port
- init_busy  out  1  init sweep in progress
- upd_ready  out  1  scheduler can absorb a worst-case cycle of requests; low requests a pipeline stall
- overflow  out  1  sticky: a request was dropped for lack of space
- protocol_err  out  1  sticky: ex_upd_valid and cr_upd_valid asserted together

## Operation
- FSM states: INIT, RUN. Reset enters INIT with sweep counter = 0.
- INIT:
  - tbl_wr_en=1, tbl_wr_index=sweep counter, tbl_wr_count=INIT_VALUE; counter +1 per cycle.
  - After writing index 2^INDEX_WIDTH-1, go to RUN.
  - Requests are ignored (not queued, no overflow); rd_count=INIT_VALUE; upd_ready=0.
- RUN, request preprocessing:
  - EX and CR are mutually exclusive. If both are valid, CR is discarded and protocol_err is set.
  - If ID and EX are valid with equal index, ID is discarded; EX wins, no error.
- Global write order: queue head to tail, then this cycle's surviving new requests in order EX, ID, CR.
- Write port each RUN cycle:
  - Queue non-empty: write the head entry.
  - Queue empty: write the first new request in the global order.
  - No request anywhere: tbl_wr_en=0.
- Enqueue: every new request not written this cycle is enqueued in global order.
- Coalescing: a new request whose index matches a queued entry (not being written this cycle) overwrites that entry's count in place and takes no new slot. It is then treated as a matching queued entry for later new requests in the same cycle.
- Space rule: if no free slot remains for a request, that request is dropped and overflow is set.
- upd_ready = RUN && free slots >= 2. At most 2 new requests arrive per cycle, so this guarantees no drops.
- Read bypass: rd_count = count of the last writer in the global order whose index equals rd_index, among the queue (excluding the entry written this cycle) and this cycle's new requests. If none matches, rd_count = rd_count_raw.
- Sticky flags clear only on reset.

## Timing
- tbl_wr_*, rd_count, upd_ready are combinational from state and this cycle's inputs. The queue, FSM, sweep counter and flags update on the clk edge.
- A request accepted with the queue empty is written in the same cycle: 0-cycle latency.
- Queued entries drain one per cycle in FIFO order.
- Init duration: exactly 2^INDEX_WIDTH cycles. First RUN cycle is cycle 2^INDEX_WIDTH after rst_n deasserts.
- Reset outputs: init_busy=1, tbl_wr_en=1 with index 0 once rst_n is high; upd_ready=0, overflow=0, protocol_err=0, queue empty.
- Reset mid-operation: queue flushed, pending updates lost, INIT restarts at index 0.
- Queue pointers wrap modulo QUEUE_DEPTH. Full and empty are distinguished by an occupancy count.

## Test plan
- Reset with INDEX_WIDTH=4: 16 writes of INIT_VALUE to indices 0..15, init_busy falls at cycle 16, upd_ready rises.
- Single cr_upd (idx 5, count 3) with queue empty: tbl_wr same cycle idx 5/3; rd_index=5 gives rd_count=3 that cycle.
- ex (idx 2, cnt 1) + id (idx 7, cnt 2) together: cycle 0 writes 2/1, cycle 1 writes 7/2. rd_index=7 in cycle 0 gives 2.
- ex and id both idx 9 (ex cnt 0, id cnt 3): only 9/0 written, nothing queued, protocol_err stays 0.
- Sustained ex+id pairs on distinct indices: queue fills, upd_ready drops at free<2; forcing one more pair sets overflow. Then a queued idx 4 entry receives a new cr on idx 4: the entry is updated in place and occupancy is unchanged.
- ex and cr valid together: only ex written, protocol_err=1. Reset mid-drain: queue empty, sweep restarts at 0.
